// File: rtl/vga_plot_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter_if
//   Bundles the CPU plot handshake, the screen-clear controls and the pixel
//   write port towards the VGA adapter.
//
//   CPU plot port      : cpu_plot, cpu_x[7:0], cpu_y[6:0], cpu_color[14:0],
//                        cpu_ready (driven by the arbiter)
//   Screen clear port  : clear_start, clear_color[14:0],
//                        clear_busy, clear_done (driven by the arbiter)
//   Status             : range_error (sticky, driven by the arbiter)
//   VGA write port     : vga_plot, vga_x[7:0], vga_y[6:0], vga_color[14:0]
//
//   modport master : the requester side (CPU / clear controller / observer)
//   modport slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface vga_plot_arbiter_if;

  // CPU plot request
  logic        cpu_plot;
  logic [7:0]  cpu_x;
  logic [6:0]  cpu_y;
  logic [14:0] cpu_color;
  logic        cpu_ready;

  // Screen clear request
  logic        clear_start;
  logic [14:0] clear_color;
  logic        clear_busy;
  logic        clear_done;

  // Status
  logic        range_error;

  // Pixel write towards the VGA adapter
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [14:0] vga_color;

  modport master (
    output cpu_plot, cpu_x, cpu_y, cpu_color,
    output clear_start, clear_color,
    input  cpu_ready, clear_busy, clear_done, range_error,
    input  vga_plot, vga_x, vga_y, vga_color
  );

  modport slave (
    input  cpu_plot, cpu_x, cpu_y, cpu_color,
    input  clear_start, clear_color,
    output cpu_ready, clear_busy, clear_done, range_error,
    output vga_plot, vga_x, vga_y, vga_color
  );

endinterface

// File: rtl/vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter
//   Shares a single VGA adapter pixel-write port between CPU plot requests and
//   a hardware full-screen fill. In IDLE the CPU may plot one pixel per cycle
//   (latency 1); a clear request takes priority and switches to CLEAR, where
//   every pixel of the screen is written in raster order, one per cycle, with
//   the colour captured when the clear was accepted.
//
//   Parameters
//     WIDTH  : screen width in pixels  (legal x = 0..WIDTH-1)
//     HEIGHT : screen height in pixels (legal y = 0..HEIGHT-1)
//
//   Ports
//     clock  : system clock, all state changes on its rising edge
//     reset  : synchronous active-high reset
//     bus    : vga_plot_arbiter_if.slave (CPU port, clear port, status,
//              VGA write port). Every output is registered except cpu_ready,
//              which is a combinational function of state and clear_start.
// -----------------------------------------------------------------------------
module vga_plot_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic               clock,
  input  logic               reset,
  vga_plot_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  // True when (x, y) lies on the visible screen.
  function automatic logic in_range(input logic [7:0] x, input logic [6:0] y);
    logic ok;
    ok = (int'({24'd0, x}) < WIDTH) && (int'({25'd0, y}) < HEIGHT);
    return ok;
  endfunction

  // Next raster position {x, y}: x runs across a line, then wraps with y+1.
  function automatic logic [14:0] raster_next(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] nxt;
    if (x == X_LAST) begin
      nxt = {8'd0, y + 7'd1};
    end else begin
      nxt = {x + 8'd1, y};
    end
    return nxt;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_x_q, cnt_x_d;
  logic [6:0]  cnt_y_q, cnt_y_d;
  logic [14:0] fill_color_q, fill_color_d;
  logic        vga_plot_q, vga_plot_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [14:0] vga_color_q, vga_color_d;
  logic        clear_busy_q, clear_busy_d;
  logic        clear_done_q, clear_done_d;
  logic        range_error_q, range_error_d;

  logic        cpu_ready_s;
  logic        fill_last_s;
  logic [7:0]  next_x_s;
  logic [6:0]  next_y_s;

  // CPU handshake: a clear request in the same cycle wins over the CPU.
  always_comb begin
    cpu_ready_s = 1'b0;
    if ((state_q == ST_IDLE) && !bus.clear_start) begin
      cpu_ready_s = 1'b1;
    end else begin
      cpu_ready_s = 1'b0;
    end
  end

  // Next-state and registered-output logic for the IDLE/CLEAR machine.
  always_comb begin
    state_d        = state_q;
    cnt_x_d        = cnt_x_q;
    cnt_y_d        = cnt_y_q;
    fill_color_d   = fill_color_q;
    vga_plot_d     = 1'b0;
    vga_x_d        = vga_x_q;
    vga_y_d        = vga_y_q;
    vga_color_d    = vga_color_q;
    clear_busy_d   = clear_busy_q;
    clear_done_d   = 1'b0;
    range_error_d  = range_error_q;

    // The counters hold the pixel currently on the VGA port during CLEAR.
    fill_last_s           = (cnt_x_q == X_LAST) && (cnt_y_q == Y_LAST);
    {next_x_s, next_y_s}  = raster_next(cnt_x_q, cnt_y_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          // Pixel (0,0) is issued straight away so the fill spans exactly
          // WIDTH*HEIGHT cycles starting the cycle after acceptance.
          state_d      = ST_CLEAR;
          fill_color_d = bus.clear_color;
          cnt_x_d      = 8'd0;
          cnt_y_d      = 7'd0;
          clear_busy_d = 1'b1;
          vga_plot_d   = 1'b1;
          vga_x_d      = 8'd0;
          vga_y_d      = 7'd0;
          vga_color_d  = bus.clear_color;
        end else if (bus.cpu_plot) begin
          if (in_range(bus.cpu_x, bus.cpu_y)) begin
            vga_plot_d  = 1'b1;
            vga_x_d     = bus.cpu_x;
            vga_y_d     = bus.cpu_y;
            vga_color_d = bus.cpu_color;
          end else begin
            // Dropped request: VGA port keeps its previous pixel.
            range_error_d = 1'b1;
          end
        end else begin
          vga_plot_d = 1'b0;
        end
      end

      ST_CLEAR: begin
        // clear_start and clear_color are deliberately not looked at here.
        if (fill_last_s) begin
          state_d      = ST_IDLE;
          clear_busy_d = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          cnt_x_d     = next_x_s;
          cnt_y_d     = next_y_s;
          vga_plot_d  = 1'b1;
          vga_x_d     = next_x_s;
          vga_y_d     = next_y_s;
          vga_color_d = fill_color_q;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        clear_busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also discards a request on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_x_q       <= 8'd0;
      cnt_y_q       <= 7'd0;
      fill_color_q  <= 15'd0;
      vga_plot_q    <= 1'b0;
      vga_x_q       <= 8'd0;
      vga_y_q       <= 7'd0;
      vga_color_q   <= 15'd0;
      clear_busy_q  <= 1'b0;
      clear_done_q  <= 1'b0;
      range_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_x_q       <= cnt_x_d;
      cnt_y_q       <= cnt_y_d;
      fill_color_q  <= fill_color_d;
      vga_plot_q    <= vga_plot_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_color_q   <= vga_color_d;
      clear_busy_q  <= clear_busy_d;
      clear_done_q  <= clear_done_d;
      range_error_q <= range_error_d;
    end
  end

  assign bus.cpu_ready   = cpu_ready_s;
  assign bus.clear_busy  = clear_busy_q;
  assign bus.clear_done  = clear_done_q;
  assign bus.range_error = range_error_q;
  assign bus.vga_plot    = vga_plot_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_color   = vga_color_q;

  vga_plot_arbiter_chk #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_chk (
    .clock       (clock),
    .reset       (reset),
    .cpu_ready   (cpu_ready_s),
    .clear_busy  (clear_busy_q),
    .clear_done  (clear_done_q),
    .range_error (range_error_q),
    .vga_plot    (vga_plot_q),
    .vga_x       (vga_x_q),
    .vga_y       (vga_y_q)
  );

endmodule

// -----------------------------------------------------------------------------
// vga_plot_arbiter_chk
//   Protocol properties of the arbiter outputs.
//   Ports: clock, reset, cpu_ready, clear_busy, clear_done, range_error,
//          vga_plot, vga_x, vga_y (all inputs).
// -----------------------------------------------------------------------------
module vga_plot_arbiter_chk #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input logic       clock,
  input logic       reset,
  input logic       cpu_ready,
  input logic       clear_busy,
  input logic       clear_done,
  input logic       range_error,
  input logic       vga_plot,
  input logic [7:0] vga_x,
  input logic [6:0] vga_y
);

  // The CPU is never granted while a fill owns the VGA port.
  a_ready_not_busy : assert property (@(posedge clock) disable iff (reset)
    !(cpu_ready && clear_busy));

  // clear_done marks the first idle cycle after a fill.
  a_done_after_busy : assert property (@(posedge clock) disable iff (reset)
    clear_done |-> (!clear_busy && $past(clear_busy)));

  // Only on-screen pixels ever reach the adapter.
  a_plot_in_range : assert property (@(posedge clock) disable iff (reset)
    vga_plot |-> ((int'({24'd0, vga_x}) < WIDTH) && (int'({25'd0, vga_y}) < HEIGHT)));

  // range_error only clears through reset.
  a_range_sticky : assert property (@(posedge clock) disable iff (reset)
    (!$past(reset) && $past(range_error)) |-> range_error);

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter WIDTH, default 160, screen width in pixels; legal x is 0..WIDTH-1.
REQ-002 Parameter HEIGHT, default 120, screen height in pixels; legal y is 0..HEIGHT-1.
REQ-003 clock  in  1  system clock; all state SHALL change on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 cpu_plot  in  1  CPU plot request.
REQ-006 cpu_x  in  8  CPU pixel x.
REQ-007 cpu_y  in  7  CPU pixel y.
REQ-008 cpu_color  in  15  CPU pixel colour.
REQ-009 cpu_ready  out  1  arbiter accepts a CPU request this cycle.
REQ-010 clear_start  in  1  one-cycle request to fill the screen with clear_color.
REQ-011 clear_color  in  15  fill colour; sampled only when a clear is accepted.
REQ-012 clear_busy  out  1  screen fill in progress.
REQ-013 clear_done  out  1  one-cycle pulse after the last fill pixel is issued.
REQ-014 range_error  out  1  sticky flag: an out-of-range CPU plot was dropped.
REQ-015 vga_plot  out  1  write strobe to the VGA adapter.
REQ-016 vga_x / vga_y / vga_color  out  8 / 7 / 15  pixel issued with vga_plot.

Function
REQ-017 The block SHALL have two FSM states: IDLE and CLEAR.
REQ-018 All outputs except cpu_ready SHALL be registered; cpu_ready SHALL be combinational: 1 iff state==IDLE and clear_start==0.
REQ-019 CPU handshake: a request SHALL be accepted on a cycle where cpu_plot=1 and cpu_ready=1; cpu_x/cpu_y/cpu_color SHALL be sampled on that edge.
REQ-020 An accepted in-range request SHALL produce vga_plot=1 with the sampled x/y/colour on the next cycle (latency 1); back-to-back requests SHALL sustain one plot per cycle.
REQ-021 An accepted request with cpu_x>=WIDTH or cpu_y>=HEIGHT SHALL NOT assert vga_plot and SHALL set range_error, which stays 1 until reset.
REQ-022 A request held while cpu_ready=0 SHALL NOT be accepted or lost; the requester keeps it asserted.
REQ-023 In IDLE, clear_start=1 SHALL move to CLEAR, latch clear_color, set x=0/y=0 counters, and assert clear_busy from the next cycle.
REQ-024 Simultaneous clear_start and cpu_plot in IDLE: clear SHALL win; the CPU request is not accepted that cycle.
REQ-025 In CLEAR the block SHALL issue exactly one vga_plot per cycle, raster order: x increments 0..WIDTH-1, then wraps to 0 with y+1, through (WIDTH-1, HEIGHT-1).
REQ-026 The first fill pixel (0,0) SHALL appear on vga_plot the cycle after clear_start is accepted; the fill SHALL last exactly WIDTH*HEIGHT cycles (19200 at defaults).
REQ-027 The cycle after pixel (WIDTH-1,HEIGHT-1) is issued, state SHALL return to IDLE, clear_busy SHALL drop to 0 and clear_done SHALL pulse 1 for one cycle.
REQ-028 clear_start asserted during CLEAR SHALL be ignored; no restart, no queueing.
REQ-029 clear_color changes during CLEAR SHALL NOT affect the fill colour.
REQ-030 cpu_ready SHALL be 0 throughout CLEAR; the CPU may resume on the cycle clear_busy reads 0.
REQ-031 vga_x/vga_y/vga_color SHALL hold their last values when vga_plot=0.

Reset
REQ-032 On reset: state=IDLE, vga_plot=0, vga_x=0, vga_y=0, vga_color=0, clear_busy=0, clear_done=0, range_error=0, counters=0.
REQ-033 Reset mid-CLEAR SHALL abort the fill immediately, with no clear_done pulse; a request accepted on the reset edge SHALL be discarded.

Verification
REQ-034 CPU plot (x=5,y=7,colour=0x7C00) in IDLE -> cpu_ready=1, vga_plot=1 with 5/7/0x7C00 next cycle only.
REQ-035 cpu_plot with x=160,y=0 -> no vga_plot, range_error=1 and remains 1 after 10 further legal plots.
REQ-036 clear_start with clear_color=0x001F, cpu_plot held -> 19200 consecutive vga_plot cycles, first (0,0), (159,0) then (0,1), last (159,119); clear_done pulses once; the held CPU request is accepted the following cycle.
REQ-037 clear_start and cpu_plot in the same IDLE cycle -> clear accepted, CPU request not accepted; clear_start re-pulsed mid-fill -> total count still 19200.
REQ-038 reset asserted at fill pixel 100 -> next cycle vga_plot=0, clear_busy=0, no clear_done; a new clear_start then restarts at (0,0).
